// File: rtl/sm83_regfile.sv
// SM83 architectural register file: A,F,B,C,D,E,H,L,SP with two byte read ports,
// per-flag writeback, {A,F} push/pop access and a 16-bit increment/decrement unit.
module sm83_regfile #(
    parameter logic [15:0] SP_RESET = 16'hFFFE,
    parameter logic [15:0] AF_RESET = 16'h01B0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  rd_sel_a,
    output logic [7:0]  rd_data_a,
    input  logic [2:0]  rd_sel_b,
    output logic [7:0]  rd_data_b,
    output logic [3:0]  flags_out,
    input  logic        wr_en,
    input  logic [2:0]  wr_sel,
    input  logic [7:0]  wr_data,
    input  logic [3:0]  flags_we,
    input  logic [3:0]  flags_in,
    input  logic [1:0]  pair_sel,
    output logic [15:0] pair_rd,
    input  logic        pair_we,
    input  logic [15:0] pair_wdata,
    input  logic [1:0]  idu_op,
    input  logic        af_we,
    output logic [15:0] af_rd
);

    logic [7:0]  a, b, c, d, e, h, l;
    logic [3:0]  flags;
    logic [15:0] sp;
    logic [63:0] bank;
    logic [15:0] pair_cur;
    logic [15:0] pair_next;
    logic        pair_upd;

    // Byte view indexed by the 3-bit select code; F's low nibble is hardwired zero.
    assign bank      = {a, flags, 4'b0000, l, h, e, d, c, b};
    assign rd_data_a = bank[{3'b000, rd_sel_a} * 8 +: 8];
    assign rd_data_b = bank[{3'b000, rd_sel_b} * 8 +: 8];
    assign flags_out = flags;
    assign af_rd     = {a, flags, 4'b0000};
    assign pair_rd   = pair_cur;

    always_comb begin
        case (pair_sel)
            2'd0:    pair_cur = {b, c};
            2'd1:    pair_cur = {d, e};
            2'd2:    pair_cur = {h, l};
            default: pair_cur = sp;
        endcase
    end

    // A pair load overrides the IDU; idu_op 3 is a no-op.
    assign pair_upd  = pair_we || (idu_op == 2'd1) || (idu_op == 2'd2);
    assign pair_next = pair_we ? pair_wdata :
                       (idu_op == 2'd1) ? pair_cur + 16'd1 : pair_cur - 16'd1;

    // Later assignments take precedence: byte write < POP AF < flag mask, and
    // byte write < pair/IDU update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a     <= AF_RESET[15:8];
            flags <= AF_RESET[7:4];
            b     <= 8'h00;
            c     <= 8'h00;
            d     <= 8'h00;
            e     <= 8'h00;
            h     <= 8'h00;
            l     <= 8'h00;
            sp    <= SP_RESET;
        end else begin
            if (wr_en) begin
                case (wr_sel)
                    3'd0:    b     <= wr_data;
                    3'd1:    c     <= wr_data;
                    3'd2:    d     <= wr_data;
                    3'd3:    e     <= wr_data;
                    3'd4:    h     <= wr_data;
                    3'd5:    l     <= wr_data;
                    3'd6:    flags <= wr_data[7:4];
                    default: a     <= wr_data;
                endcase
            end
            if (af_we) begin
                a     <= pair_wdata[15:8];
                flags <= pair_wdata[7:4];
            end
            for (int i = 0; i < 4; i++) begin
                if (flags_we[i]) flags[i] <= flags_in[i];
            end
            if (pair_upd) begin
                case (pair_sel)
                    2'd0:    {b, c} <= pair_next;
                    2'd1:    {d, e} <= pair_next;
                    2'd2:    {h, l} <= pair_next;
                    default: sp     <= pair_next;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sm83_regfile.sv
// Randomized scoreboard bench for sm83_regfile against a byte-array reference model.
module tb_sm83_regfile;

    localparam logic [15:0] SP_RST = 16'hFFFE;
    localparam logic [15:0] AF_RST = 16'h01B0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  rd_sel_a = '0, rd_sel_b = '0, wr_sel = '0;
    logic [7:0]  rd_data_a, rd_data_b, wr_data = '0;
    logic [3:0]  flags_out, flags_we = '0, flags_in = '0;
    logic        wr_en = 1'b0, pair_we = 1'b0, af_we = 1'b0;
    logic [1:0]  pair_sel = '0, idu_op = '0;
    logic [15:0] pair_rd, pair_wdata = '0, af_rd;

    always #5 clk = ~clk;

    sm83_regfile #(.SP_RESET(SP_RST), .AF_RESET(AF_RST)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_sel_a(rd_sel_a), .rd_data_a(rd_data_a),
        .rd_sel_b(rd_sel_b), .rd_data_b(rd_data_b),
        .flags_out(flags_out),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .flags_we(flags_we), .flags_in(flags_in),
        .pair_sel(pair_sel), .pair_rd(pair_rd),
        .pair_we(pair_we), .pair_wdata(pair_wdata),
        .idu_op(idu_op), .af_we(af_we), .af_rd(af_rd)
    );

    typedef struct packed {
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [3:0]  fl;
        logic [15:0] pr;
        logic [15:0] af;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // Reference state: m[0..5]=B,C,D,E,H,L, m[6]=F (low nibble kept 0), m[7]=A.
    logic [7:0]  m[8];
    logic [15:0] msp;

    function automatic logic [15:0] pair_get(input logic [1:0] p);
        if (p == 2'd3) return msp;
        return {m[2*p], m[2*p+1]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m[i] = 8'h00;
        m[6] = AF_RST[7:0] & 8'hF0;
        m[7] = AF_RST[15:8];
        msp  = SP_RST;
    endtask

    task automatic model_update();
        logic [7:0]  n[8];
        logic [15:0] nsp, pv;
        for (int i = 0; i < 8; i++) n[i] = m[i];
        nsp = msp;
        if (wr_en) n[wr_sel] = (wr_sel == 3'd6) ? (wr_data & 8'hF0) : wr_data;
        if (af_we) begin
            n[7] = pair_wdata[15:8];
            n[6] = pair_wdata[7:0] & 8'hF0;
        end
        for (int i = 0; i < 4; i++)
            if (flags_we[i]) n[6][4+i] = flags_in[i];
        if (pair_we || idu_op == 2'd1 || idu_op == 2'd2) begin
            if (pair_we)            pv = pair_wdata;
            else if (idu_op == 2'd1) pv = pair_get(pair_sel) + 16'd1;
            else                     pv = pair_get(pair_sel) - 16'd1;
            if (pair_sel == 2'd3) nsp = pv;
            else begin
                n[2*pair_sel]   = pv[15:8];
                n[2*pair_sel+1] = pv[7:0];
            end
        end
        for (int i = 0; i < 8; i++) m[i] = n[i];
        msp = nsp;
    endtask

    task automatic idle();
        wr_en = 0; wr_sel = 0; wr_data = 0; flags_we = 0; flags_in = 0;
        pair_we = 0; pair_wdata = 0; idu_op = 0; af_we = 0;
    endtask

    // Called just after a rising edge: inputs are already driven for this cycle.
    task automatic step();
        exp_t ex;
        ex.ra = m[rd_sel_a];
        ex.rb = m[rd_sel_b];
        ex.fl = m[6][7:4];
        ex.pr = pair_get(pair_sel);
        ex.af = {m[7], m[6]};
        q.push_back(ex);
        if (rst_n) model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, between input drive and the next edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t ex;
            ex = q.pop_front();
            chk("rd_data_a", {8'h00, rd_data_a}, {8'h00, ex.ra});
            chk("rd_data_b", {8'h00, rd_data_b}, {8'h00, ex.rb});
            chk("flags_out", {12'h000, flags_out}, {12'h000, ex.fl});
            chk("pair_rd", pair_rd, ex.pr);
            chk("af_rd", af_rd, ex.af);
        end
    end

    task automatic rand_cycle();
        idle();
        rd_sel_a = 3'($urandom_range(0, 7));
        rd_sel_b = 3'($urandom_range(0, 7));
        pair_sel = 2'($urandom_range(0, 3));
        wr_en    = ($urandom_range(0, 1) == 1);
        wr_sel   = 3'($urandom_range(0, 7));
        wr_data  = 8'($urandom);
        idu_op   = 2'($urandom_range(0, 3));
        pair_we  = ($urandom_range(0, 3) == 0);
        pair_wdata = 16'($urandom);
        // Bias pair values toward the wrap points.
        if ($urandom_range(0, 7) == 0) pair_wdata = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
        af_we    = ($urandom_range(0, 5) == 0);
        if (!af_we) begin
            flags_we = 4'($urandom);
            flags_in = 4'($urandom);
        end
        step();
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        // Reset held: all reads show reset values.
        rd_sel_a = 3'd7; rd_sel_b = 3'd6; pair_sel = 2'd3;
        wr_en = 1; wr_sel = 3'd7; wr_data = 8'h55;
        step();
        idle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_sel_a = 3'(i); rd_sel_b = 3'(i + 4); pair_sel = 2'(i);
            step();
        end
        // Write D=5A: same-cycle read still old, next cycle new.
        rd_sel_a = 3'd2; rd_sel_b = 3'd6;
        wr_en = 1; wr_sel = 3'd2; wr_data = 8'h5A;
        step();
        idle();
        step();
        // Flag masks.
        flags_we = 4'b0101; flags_in = 4'b0100;
        step();
        flags_we = 4'b0001; flags_in = 4'b0000;
        step();
        idle();
        // IDU wrap on HL and SP.
        pair_sel = 2'd2; pair_we = 1; pair_wdata = 16'hFFFF;
        step();
        pair_we = 0; idu_op = 2'd1;
        step();
        idu_op = 2'd0;
        step();
        pair_sel = 2'd3; pair_we = 1; pair_wdata = 16'h0000;
        step();
        pair_we = 0; idu_op = 2'd2;
        step();
        idu_op = 2'd3;
        step();
        // Collisions.
        pair_sel = 2'd2; pair_we = 1; pair_wdata = 16'h1234; idu_op = 2'd1;
        wr_en = 1; wr_sel = 3'd4; wr_data = 8'hFF; rd_sel_a = 3'd4; rd_sel_b = 3'd5;
        step();
        idle();
        af_we = 1; pair_wdata = 16'hABCD; wr_en = 1; wr_sel = 3'd7; wr_data = 8'h11;
        rd_sel_a = 3'd7;
        step();
        idle();
        af_we = 1; pair_wdata = 16'h12FF;
        step();
        idle();
        step();
        for (int i = 0; i < 300; i++) rand_cycle();
        // Asynchronous reset mid-cycle with a write pending.
        idle();
        wr_en = 1; wr_sel = 3'd0; wr_data = 8'hC3; pair_we = 1; pair_sel = 2'd3; pair_wdata = 16'h4444;
        rst_n = 1'b0;
        model_reset();
        step();
        idle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_sel_a = 3'(i); rd_sel_b = 3'(i + 4); pair_sel = 2'(i);
            step();
        end
        for (int i = 0; i < 100; i++) rand_cycle();
        idle();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
